matrix_stream_loader: RTL
=========================

// Module: matrix_stream_loader
// PURPOSE
//  Upstream feeder for matrix_mult1. Receives a byte stream (header plus row-major elements)
//  and packs the elements into the flat A/B buses. Drives the dimension ports, then sequences
//  the multiplier: reset pulse, hold enable, wait for done. One job in flight at a time.
// PARAMETERS
//  DW         8     element width in bits
//  MAX_ELEMS  1024  max elements per matrix; BUS_W = DW*MAX_ELEMS = 8192
// PORTS
//  clk         in   1      single clock; all logic on posedge clk
//  reset       in   1      asynchronous, active-high reset
//  in_valid    in   1      byte-stream valid
//  in_data     in   DW     byte-stream data
//  in_ready    out  1      loader accepts a byte; transfer = in_valid & in_ready
//  A           out  BUS_W  packed matrix A; element (i,j) at [(i*Ay+j)*DW +: DW]
//  B           out  BUS_W  packed matrix B; element (i,j) at [(i*By+j)*DW +: DW]
//  Ax,Ay,Bx,By out  8      rows/cols of A and B, as received
//  mult_rst_n  out  1      active-low reset to multiplier
//  mult_enable out  1      held high while the multiplier runs
//  mult_done   in   1      multiplier completion flag (level)
//  busy        out  1      high from first header byte until job_done
//  hdr_err     out  1      1-cycle pulse: header rejected
//  job_done    out  1      1-cycle pulse: multiplier reported done
// BEHAVIOUR
//  Reset values: in_ready=0, A=B=0, Ax..By=0, mult_rst_n=0, mult_enable=0, busy=0,
//    hdr_err=0, job_done=0, state=S_HDR, all counters 0. Reset mid-job aborts unconditionally.
//  Frame order: Ax, Ay, Bx, By, then Ax*Ay bytes of A, then Bx*By bytes of B, row-major.
//  S_HDR: in_ready=1; hdr_cnt 0..3 stores the dimension bytes. On 4th byte -> S_CHK.
//    busy rises on the cycle after the first accepted byte.
//  S_CHK (1 cycle, in_ready=0): nA=Ax*Ay, nB=Bx*By (16-bit unsigned).
//    Reject if any dim==0, Ay!=Bx, nA>MAX_ELEMS, or nB>MAX_ELEMS.
//    Reject: hdr_err pulse, busy=0, -> S_HDR. Loader consumes no further bytes; the sender
//    owns framing.
//    Accept: clear A and B to 0, elem_cnt=0, -> S_LDA.
//  S_LDA: in_ready=1; each transfer writes A[elem_cnt*DW +: DW] and increments elem_cnt.
//    On byte nA: elem_cnt=0, -> S_LDB.
//  S_LDB: same for B with nB; on last byte -> S_CLR.
//  in_valid gaps stall a state without side effects. Counters never exceed nA-1 or nB-1.
//  S_CLR (1 cycle): in_ready=0, mult_rst_n=0, mult_enable=0. Then -> S_RUN.
//  S_RUN: mult_rst_n=1, mult_enable=1. A, B and dims are held stable.
//    On the first cycle with mult_done=1: job_done pulse, mult_enable=0 next cycle, busy=0,
//    -> S_HDR.
//    mult_done sampled in the first S_RUN cycle counts (no minimum run length).
//    No timeout: S_RUN waits indefinitely.
//  Outside S_CLR, mult_rst_n stays 1 after the first job. A/B/dims persist until the next
//    header is accepted.
// STRUCTURE
//  matmul_pkg: DW, MAX_ELEMS, BUS_W, state encoding (S_HDR,S_CHK,S_LDA,S_LDB,S_CLR,S_RUN),
//    counter width clog2(MAX_ELEMS+1)=11.
//  Sub-module matrix_hdr_check: combinational; dims in -> nA, nB, ok out.
//  Top holds the FSM, counters and pack registers. Element writes use an indexed part-select.
// TESTING
//  1 2x2: hdr 2,2,2,2; A=1,2,3,4; B=5,6,7,8 -> A[31:0]=0x04030201, B[31:0]=0x08070605,
//    mult_rst_n low exactly 1 cycle, then enable=1; mult_done -> job_done pulse, busy=0.
//  2 Mismatch: hdr 2,3,2,2 -> hdr_err pulse, A/B unchanged, in_ready=1 in S_HDR; a following
//    2x2 frame loads correctly.
//  3 Limits: hdr 32,32,32,32 (1024) accepted, last A byte at A[8191:8184];
//    hdr 33,32,32,32 -> hdr_err; hdr 0,1,1,1 -> hdr_err.
//  4 Non-square: hdr 1,3,3,2; A=9,8,7; B=1..6 -> A[23:0]=0x070809, B[47:0]=0x060504030201,
//    upper bits zero.
//  5 Backpressure: random in_valid gaps during a 3x3 load -> same packed result as
//    gap-free; no byte accepted in S_CHK/S_CLR/S_RUN.
//  6 Reset mid-S_LDB, then a mid-S_RUN reset -> all outputs at reset values next edge;
//    mult_rst_n=0; a new frame loads cleanly.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared constants and FSM state type for the matrix stream loader and its header checker.
package matmul_pkg;

   localparam int DW        = 8;
   localparam int MAX_ELEMS = 1024;
   localparam int BUS_W     = DW * MAX_ELEMS;
   localparam int CNT_W     = $clog2(MAX_ELEMS + 1);

   typedef enum logic [2:0] {
      S_HDR,
      S_CHK,
      S_LDA,
      S_LDB,
      S_CLR,
      S_RUN
   } state_t;

endpackage

// File: rtl/matrix_hdr_check.sv
// Combinational header validation: element counts of A and B and an accept flag.
module matrix_hdr_check
   import matmul_pkg::*;
(
   input  logic [7:0]  ax_i,
   input  logic [7:0]  ay_i,
   input  logic [7:0]  bx_i,
   input  logic [7:0]  by_i,
   output logic [15:0] na_o,
   output logic [15:0] nb_o,
   output logic        ok_o
);

   assign na_o = 16'(ax_i) * 16'(ay_i);
   assign nb_o = 16'(bx_i) * 16'(by_i);

   assign ok_o = (ax_i != '0) && (ay_i != '0) && (bx_i != '0) && (by_i != '0)
              && (ay_i == bx_i)
              && (na_o <= 16'(MAX_ELEMS))
              && (nb_o <= 16'(MAX_ELEMS));

endmodule

// File: rtl/matrix_stream_loader.sv
// Byte-stream loader: packs header-described A/B matrices into flat buses, then
// sequences one multiplier run (reset pulse, enable, wait for done).
module matrix_stream_loader
   import matmul_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [DW-1:0]    in_data,
   output logic             in_ready,
   output logic [BUS_W-1:0] A,
   output logic [BUS_W-1:0] B,
   output logic [7:0]       Ax,
   output logic [7:0]       Ay,
   output logic [7:0]       Bx,
   output logic [7:0]       By,
   output logic             mult_rst_n,
   output logic             mult_enable,
   input  logic             mult_done,
   output logic             busy,
   output logic             hdr_err,
   output logic             job_done
);

   state_t             state_q;
   logic [1:0]         hdr_cnt_q;
   logic [7:0]         hdr_q [4];
   logic [CNT_W-1:0]   elem_cnt_q;
   logic [BUS_W-1:0]   a_q, b_q;
   logic [7:0]         ax_q, ay_q, bx_q, by_q;
   logic               in_ready_q, mult_rst_n_q, mult_enable_q;
   logic               busy_q, hdr_err_q, job_done_q;

   logic [15:0]        n_a, n_b;
   logic               hdr_ok, xfer, a_last, b_last;

   // Checker sees the shadow header so the live dims hold until a header is accepted.
   matrix_hdr_check u_hdr_check (
      .ax_i (hdr_q[0]),
      .ay_i (hdr_q[1]),
      .bx_i (hdr_q[2]),
      .by_i (hdr_q[3]),
      .na_o (n_a),
      .nb_o (n_b),
      .ok_o (hdr_ok)
   );

   assign xfer   = in_valid & in_ready_q;
   assign a_last = (16'(elem_cnt_q) == n_a - 16'd1);
   assign b_last = (16'(elem_cnt_q) == n_b - 16'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_HDR;
         hdr_cnt_q     <= '0;
         for (int unsigned i = 0; i < 4; i++) hdr_q[i] <= '0;
         elem_cnt_q    <= '0;
         a_q           <= '0;
         b_q           <= '0;
         ax_q          <= '0;
         ay_q          <= '0;
         bx_q          <= '0;
         by_q          <= '0;
         in_ready_q    <= 1'b0;
         mult_rst_n_q  <= 1'b0;
         mult_enable_q <= 1'b0;
         busy_q        <= 1'b0;
         hdr_err_q     <= 1'b0;
         job_done_q    <= 1'b0;
      end else begin
         hdr_err_q  <= 1'b0;
         job_done_q <= 1'b0;
         unique case (state_q)
            S_HDR: begin
               in_ready_q <= 1'b1;
               if (xfer) begin
                  hdr_q[hdr_cnt_q] <= in_data;
                  busy_q           <= 1'b1;
                  hdr_cnt_q        <= hdr_cnt_q + 2'd1;
                  if (hdr_cnt_q == 2'd3) begin
                     state_q    <= S_CHK;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            S_CHK: begin
               in_ready_q <= 1'b1;
               if (hdr_ok) begin
                  a_q        <= '0;
                  b_q        <= '0;
                  ax_q       <= hdr_q[0];
                  ay_q       <= hdr_q[1];
                  bx_q       <= hdr_q[2];
                  by_q       <= hdr_q[3];
                  elem_cnt_q <= '0;
                  state_q    <= S_LDA;
               end else begin
                  hdr_err_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_HDR;
               end
            end
            S_LDA: begin
               if (xfer) begin
                  a_q[elem_cnt_q*DW +: DW] <= in_data;
                  if (a_last) begin
                     elem_cnt_q <= '0;
                     state_q    <= S_LDB;
                  end else begin
                     elem_cnt_q <= elem_cnt_q + 1'b1;
                  end
               end
            end
            S_LDB: begin
               if (xfer) begin
                  b_q[elem_cnt_q*DW +: DW] <= in_data;
                  if (b_last) begin
                     elem_cnt_q    <= '0;
                     state_q       <= S_CLR;
                     in_ready_q    <= 1'b0;
                     mult_rst_n_q  <= 1'b0;
                     mult_enable_q <= 1'b0;
                  end else begin
                     elem_cnt_q <= elem_cnt_q + 1'b1;
                  end
               end
            end
            S_CLR: begin
               mult_rst_n_q  <= 1'b1;
               mult_enable_q <= 1'b1;
               state_q       <= S_RUN;
            end
            S_RUN: begin
               if (mult_done) begin
                  job_done_q    <= 1'b1;
                  mult_enable_q <= 1'b0;
                  busy_q        <= 1'b0;
                  in_ready_q    <= 1'b1;
                  state_q       <= S_HDR;
               end
            end
            default: state_q <= S_HDR;
         endcase
      end
   end

   assign in_ready    = in_ready_q;
   assign A           = a_q;
   assign B           = b_q;
   assign Ax          = ax_q;
   assign Ay          = ay_q;
   assign Bx          = bx_q;
   assign By          = by_q;
   assign mult_rst_n  = mult_rst_n_q;
   assign mult_enable = mult_enable_q;
   assign busy        = busy_q;
   assign hdr_err     = hdr_err_q;
   assign job_done    = job_done_q;

endmodule
